icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
//  Direct-mapped, one-word-per-block instruction cache between the datapath fetch stage and
//  the instruction port of memory_control (iREN/iaddr/iload/iwait).
//  Hits return in the same cycle. Misses stall the fetch stage while one word is fetched
//  from RAM through the arbiter, then the block is refilled.
//  Also provides flush and hit/miss counters for halt-time statistics.
// PARAMETERS
//  NSETS      16   number of frames; power of 2, >= 2; IDXW = $clog2(NSETS)
//  CNTW       32   width of hit/miss statistic counters
// PORTS
//  CLK        in   1      clock, all state updates on rising edge
//  RST        in   1      synchronous reset, active-high
//  imemREN    in   1      datapath requests an instruction this cycle
//  imemaddr   in   32     instruction byte address; bits[1:0] ignored
//  ihit       out  1      imemload valid this cycle; fetch stage may advance
//  imemload   out  32     instruction word (frame data on hit, else 0)
//  flush      in   1      invalidate all frames
//  iREN       out  1      read request to memory_control
//  iaddr      out  32     word-aligned miss address to memory_control
//  iload      in   32     RAM data from memory_control
//  iwait      in   1      memory_control stall; 0 = iload valid this cycle
//  hit_count  out  CNTW   hits since reset (wraps)
//  miss_count out  CNTW   misses since reset (wraps)
// BEHAVIOUR
//  Address split: tag = imemaddr[31:IDXW+2], idx = imemaddr[IDXW+1:2], off = [1:0] (ignored).
//  Frame state: valid, tag, data[31:0]. Reset (RST=1 at edge): all valid=0, state=IDLE,
//   miss_addr=0, both counters=0. During reset cycle ihit=0, iREN=0, iaddr=0.
//  FSM states IDLE, FETCH:
//   IDLE: hit = imemREN & valid[idx] & tag match. On hit: ihit=1 combinationally, imemload=data,
//    hit_count+1 at edge. On imemREN & miss: ihit=0, latch miss_addr={imemaddr[31:2],2'b00},
//    miss_count+1, go FETCH. iREN=0 in IDLE. imemREN=0: ihit=0, no change.
//   FETCH: iREN=1, iaddr=miss_addr, ihit=0. While iwait=1: hold. When iwait=0: write
//    frame[miss idx] <= {1, miss tag, iload}, go IDLE. Next cycle the same address hits.
//   Miss-to-hit latency = (cycles iwait stays high) + 2 cycles.
//   imemaddr changing during FETCH (branch redirect): fill still completes for miss_addr.
//    IDLE then re-evaluates the new address. No abort is issued to memory_control.
//  iaddr holds miss_addr in all states (stable, no glitch onto the arbiter address mux).
//  flush: at edge, all valid bits <= 0. flush in the same cycle as a fill write: all frames
//   invalid except the filled frame, which is written valid. flush in IDLE with a hit: ihit still 1
//   this cycle and counted; the frame is invalid from the next cycle.
//  Counters increment once per hit cycle / once per miss (not per stall cycle). They wrap
//   at 2^CNTW. Counters are not affected by flush.
//  RST mid-FETCH: FSM -> IDLE, iREN drops the next cycle, fill discarded, frames invalid.
// STRUCTURE
//  cpu_types_pkg gets: typedef icachef_t {tag, idx, bytoff} packed address split;
//   typedef icache_frame_t {logic valid; tag; word_t data}; enum icache_state_t {IDLE,FETCH}.
//  One sub-module: icache_frames (NSETS-entry frame array: 1 comb read port, 1 write port,
//   bulk valid clear). FSM and counters are in the top-level module.
// TESTING
//  Cold miss: reset, imemREN=1 addr=0x0000_0040, iwait=1 for 3 cycles then 0 with
//   iload=0xDEAD_BEEF -> iREN=1 and iaddr=0x40 for 4 cycles. Next cycle ihit=1,
//   imemload=0xDEADBEEF, miss_count=1, hit_count=1.
//  Conflict: fill 0x40, then request 0x80 (NSETS=16, same idx 0, different tag) -> miss and
//   refill. Re-request 0x40 -> miss again; miss_count=3.
//  Redirect mid-miss: miss on 0x100, change imemaddr to 0x104 while iwait=1 -> iaddr stays 0x100.
//   After fill, 0x104 misses with iaddr=0x104. Later 0x100 hits.
//  Flush: fill 0x0/0x4/0x8, pulse flush -> next requests of each miss. flush in the same cycle as
//   the fill of 0xC -> only 0xC hits afterwards.
//  Reset mid-FETCH: assert RST while iwait=1 -> next cycle iREN=0, ihit=0, counters 0, and the
//   prior address misses.
//  Misaligned/offset: fill 0x200, request 0x203 -> hit with the same data. iaddr is always
//   word-aligned.

Source files
------------

// File: rtl/icache_direct_mapped_pkg.sv
`default_nettype none
// ============================================================================
// icache_direct_mapped_pkg : shared types and FSM encodings for the I-cache
// Revision: 1.0
// ============================================================================
package icache_direct_mapped_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_NSETS = 16;
  localparam int ICACHE_IDXW  = $clog2(ICACHE_NSETS);
  localparam int ICACHE_TAGW  = 30 - ICACHE_IDXW;

  // Address split for the default geometry.
  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDXW-1:0] idx;
    logic [1:0]             bytoff;
  } icachef_t;

  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    word_t                  data;
  } icache_frame_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_frames.sv
`default_nettype none
// ============================================================================
// icache_frames : frame array, one combinational read port, one write port,
//                 bulk valid clear. Revision: 1.0
// ============================================================================
module icache_frames
  import icache_direct_mapped_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int IDXW  = $clog2(NSETS),
  parameter int TAGW  = 30 - IDXW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [IDXW-1:0] rd_idx,
  output logic            rd_valid,
  output logic [TAGW-1:0] rd_tag,
  output word_t           rd_data,
  input  logic            we,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [TAGW-1:0] wr_tag,
  input  word_t           wr_data
);

  logic [NSETS-1:0] valid;
  logic [TAGW-1:0]  tags [NSETS];
  word_t            data [NSETS];

  // A write in the same cycle as a clear leaves the written frame valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (clear) valid <= '0;
      if (we)    valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// icache_direct_mapped : direct-mapped one-word-block instruction cache with
//                        flush and hit/miss statistics. Revision: 1.0
// ============================================================================
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int CNTW  = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            imemREN,
  input  logic [31:0]     imemaddr,
  output logic            ihit,
  output logic [31:0]     imemload,
  input  logic            flush,
  output logic            iREN,
  output logic [31:0]     iaddr,
  input  logic [31:0]     iload,
  input  logic            iwait,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] miss_count
);

  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 30 - IDXW;

  logic [0:0]      state;
  logic [31:0]     miss_addr;
  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] req_idx;
  logic            rd_valid;
  logic [TAGW-1:0] rd_tag;
  word_t           rd_data;
  logic            hit;
  logic            miss;
  logic            fill;
  logic            unused_offset;

  assign req_tag       = imemaddr[31:IDXW+2];
  assign req_idx       = imemaddr[IDXW+1:2];
  assign unused_offset = &{1'b0, imemaddr[1:0]};

  assign hit  = !RST && (state == ST_IDLE) && imemREN && rd_valid && (rd_tag == req_tag);
  assign miss = !RST && (state == ST_IDLE) && imemREN && !hit;
  assign fill = !RST && (state == ST_FETCH) && !iwait;

  assign ihit     = hit;
  assign imemload = hit ? rd_data : '0;
  assign iREN     = !RST && (state == ST_FETCH);
  // Held at the latched miss address so the arbiter sees a stable value.
  assign iaddr    = RST ? '0 : miss_addr;

  icache_frames #(
    .NSETS (NSETS),
    .IDXW  (IDXW),
    .TAGW  (TAGW)
  ) u_frames (
    .clk      (CLK),
    .rst      (RST),
    .clear    (flush),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill),
    .wr_idx   (miss_addr[IDXW+1:2]),
    .wr_tag   (miss_addr[31:IDXW+2]),
    .wr_data  (iload)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      miss_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) hit_count <= hit_count + 1'b1;
          if (miss) begin
            miss_addr  <= word_align(imemaddr);
            miss_count <= miss_count + 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (fill) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// tb_icache_direct_mapped : directed bench for icache_direct_mapped
// Revision: 1.0
// ============================================================================
module tb_icache_direct_mapped;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  icache_direct_mapped #(.NSETS(16), .CNTW(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .flush      (flush),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iload      (iload),
    .iwait      (iwait),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Miss on addr in IDLE, then one FETCH cycle with iwait=0; returns in IDLE.
  task automatic fill(input logic [31:0] addr, input logic [31:0] data);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b0; iload = data;
    cyc();
    cyc();
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iload = '0; iwait = 1'b1;
    cyc();
    imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_hitcnt", hit_count, 32'd0);
    chk("rst_misscnt", miss_count, 32'd0);

    // Cold miss with three wait cycles
    cyc();
    RST = 1'b0;
    #1;
    chk("cold_idle_ihit", {31'd0, ihit}, 32'd0);
    chk("cold_idle_iren", {31'd0, iREN}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) begin
        iwait = 1'b0; iload = 32'hDEAD_BEEF;
      end
      #1;
      chk("cold_fetch_iren", {31'd0, iREN}, 32'd1);
      chk("cold_fetch_iaddr", iaddr, 32'h40);
      chk("cold_fetch_ihit", {31'd0, ihit}, 32'd0);
    end
    cyc();
    iwait = 1'b1;
    #1;
    chk("cold_hit", {31'd0, ihit}, 32'd1);
    chk("cold_data", imemload, 32'hDEAD_BEEF);
    chk("cold_idle_iren2", {31'd0, iREN}, 32'd0);
    cyc();
    imemREN = 1'b0;
    #1;
    chk("cold_hitcnt", hit_count, 32'd1);
    chk("cold_misscnt", miss_count, 32'd1);

    // Conflict on index 0
    fill(32'h80, 32'h1111_1111);
    #1;
    chk("conf_hit80", {31'd0, ihit}, 32'd1);
    chk("conf_data80", imemload, 32'h1111_1111);
    cyc();
    imemaddr = 32'h40;
    #1;
    chk("conf_miss40", {31'd0, ihit}, 32'd0);
    fill(32'h40, 32'hDEAD_BEEF);
    imemREN = 1'b0;
    #1;
    chk("conf_misscnt", miss_count, 32'd3);

    // Redirect while the miss is outstanding
    imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
    cyc();
    imemaddr = 32'h104;
    #1;
    chk("redir_iaddr", iaddr, 32'h100);
    cyc();
    iwait = 1'b0; iload = 32'hAAAA_0100;
    #1;
    chk("redir_iaddr2", iaddr, 32'h100);
    cyc();
    #1;
    chk("redir_miss104", {31'd0, ihit}, 32'd0);
    iload = 32'hBBBB_0104;
    cyc();
    #1;
    chk("redir_iaddr104", iaddr, 32'h104);
    cyc();
    imemaddr = 32'h100;
    #1;
    chk("redir_hit100", {31'd0, ihit}, 32'd1);
    chk("redir_data100", imemload, 32'hAAAA_0100);
    cyc();

    // Flush
    fill(32'h0, 32'h0000_1000);
    fill(32'h4, 32'h0000_1004);
    fill(32'h8, 32'h0000_1008);
    imemREN = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0; imemREN = 1'b1;
    for (int a = 0; a < 12; a += 4) begin
      imemaddr = a;
      #1;
      chk("flush_miss", {31'd0, ihit}, 32'd0);
      iload = 32'h0000_2000 + a;
      cyc();
      cyc();
    end
    imemaddr = 32'hC; iload = 32'hCCCC_000C;
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    chk("flushfill_hitC", {31'd0, ihit}, 32'd1);
    chk("flushfill_dataC", imemload, 32'hCCCC_000C);
    cyc();
    imemaddr = 32'h4;
    #1;
    chk("flushfill_miss4", {31'd0, ihit}, 32'd0);
    cyc();
    cyc();
    imemaddr = 32'hC; flush = 1'b1;
    #1;
    chk("flushhit_ihit", {31'd0, ihit}, 32'd1);
    cyc();
    flush = 1'b0;
    #1;
    chk("flushhit_after", {31'd0, ihit}, 32'd0);

    // Reset while FETCH is waiting
    imemaddr = 32'h300; iwait = 1'b1;
    cyc();
    #1;
    chk("rstf_iren_pre", {31'd0, iREN}, 32'd1);
    RST = 1'b1;
    cyc();
    RST = 1'b0; imemaddr = 32'hC; iwait = 1'b0; iload = 32'h5555_000C;
    #1;
    chk("rstf_iren", {31'd0, iREN}, 32'd0);
    chk("rstf_ihit", {31'd0, ihit}, 32'd0);
    chk("rstf_hitcnt", hit_count, 32'd0);
    chk("rstf_misscnt", miss_count, 32'd0);
    cyc();
    cyc();

    // Byte offset ignored
    fill(32'h200, 32'h1234_5678);
    imemaddr = 32'h203;
    #1;
    chk("off_hit", {31'd0, ihit}, 32'd1);
    chk("off_data", imemload, 32'h1234_5678);
    cyc();
    imemaddr = 32'h20B;
    #1;
    chk("off_miss", {31'd0, ihit}, 32'd0);
    cyc();
    #1;
    chk("off_iaddr", iaddr, 32'h208);
    cyc();
    imemREN = 1'b0;
    #1;
    chk("end_hitcnt", hit_count, 32'd1);
    chk("end_misscnt", miss_count, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
